// File: rtl/led_arb_pkg.sv
// Shared types and sizing helpers for the LED display arbiter.
package led_arb_pkg;

  localparam int LED_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  // Hold counter width; at least one bit so HOLD_CYCLES==2 still has a counter.
  function automatic int cnt_w(input int hold_cycles);
    return (hold_cycles > 2) ? $clog2(hold_cycles) : 1;
  endfunction

endpackage

// File: rtl/led_rr_picker.sv
// Combinational round-robin picker: first active request after i_ptr, wrapping.
module led_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_winner,
  output logic               o_vld
);

  logic w_found;

  always_comb begin
    o_winner = '0;
    w_found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
        o_winner[(int'(i_ptr) + k) % NUM_REQ] = 1'b1;
        w_found = 1'b1;
      end
    end
    o_vld = w_found;
  end

endmodule

// File: rtl/led_display_arbiter.sv
// Round-robin owner of the 16-LED bank with a rotating heartbeat when idle.
// Optional macro LED_ARB_PREEMPT_EN: requester 0 is high priority and preempts holders.
module led_display_arbiter
  import led_arb_pkg::*;
#(
  parameter int               NUM_REQ     = 4,
  parameter int               HOLD_CYCLES = 50000000,
  parameter logic [LED_W-1:0] IDLE_SEED   = 16'h0001
) (
  input  logic                     clk100m,
  input  logic                     rstn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [LED_W*NUM_REQ-1:0] pattern,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [LED_W-1:0]         leds
);

  localparam int               PTR_W    = $clog2(NUM_REQ);
  localparam int               CNT_W    = cnt_w(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_REQ - 1);

  arb_state_t         r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [PTR_W-1:0]   r_owner, w_owner_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0] r_done, w_done_nxt;
  logic               r_busy, w_busy_nxt;
  logic [LED_W-1:0]   r_leds, w_leds_nxt;
  logic [LED_W-1:0]   r_hb, w_hb_nxt;

  logic [NUM_REQ-1:0] w_rr_win;
  logic               w_rr_vld;
  logic [NUM_REQ-1:0] w_win;
  logic [PTR_W-1:0]   w_win_idx;
  logic               w_take;
  logic               w_last;

  led_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_winner (w_rr_win),
    .o_vld    (w_rr_vld)
  );

`ifdef LED_ARB_PREEMPT_EN
  assign w_win = req[0] ? NUM_REQ'(1) : w_rr_win;
`else
  assign w_win = w_rr_win;
`endif

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win[i]) w_win_idx = PTR_W'(i);
    end
  end

  assign w_last = (r_cnt == CNT_LAST);

  always_ff @(posedge clk100m) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ptr   <= PTR_RST;
      r_owner <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_leds  <= IDLE_SEED;
      r_hb    <= IDLE_SEED;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
      r_leds  <= w_leds_nxt;
      r_hb    <= w_hb_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_grant_nxt = r_grant;
    w_done_nxt  = '0;
    w_busy_nxt  = r_busy;
    w_leds_nxt  = r_leds;
    w_hb_nxt    = r_hb;
    w_take      = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_rr_vld) begin
          w_take   = 1'b1;
          w_hb_nxt = r_leds;
        end else if (w_last) begin
          w_leds_nxt = {r_leds[LED_W-2:0], r_leds[LED_W-1]};
          w_cnt_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        // Completion wins over a same-cycle drop so the owner still sees done.
        if (w_last) begin
          w_done_nxt  = r_grant;
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = GAP;
        end
`ifdef LED_ARB_PREEMPT_EN
        else if ((r_owner != '0) && req[0]) begin
          w_grant_nxt = NUM_REQ'(1);
          w_leds_nxt  = pattern[LED_W-1:0];
          w_owner_nxt = '0;
          w_cnt_nxt   = '0;
        end
`endif
        else if (!req[r_owner]) begin
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = GAP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (w_rr_vld) begin
          w_take = 1'b1;
        end else begin
          w_leds_nxt  = r_hb;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_take) begin
      w_state_nxt = HOLD;
      w_grant_nxt = w_win;
      w_busy_nxt  = 1'b1;
      w_leds_nxt  = pattern[LED_W*int'(w_win_idx) +: LED_W];
      w_cnt_nxt   = '0;
      w_ptr_nxt   = w_win_idx;
      w_owner_nxt = w_win_idx;
    end
  end

  assign grant = r_grant;
  assign done  = r_done;
  assign busy  = r_busy;
  assign leds  = r_leds;

endmodule
